snax_simd_alu_shell_wrapper: RTL

//  Parametrised SNAX accelerator shell: NumLanes-wide SIMD ALU joining two streamer inputs into one widened output stream.

---
 rtl/snax_simd_alu_shell_wrapper.sv | 138 +++++++++++++
 1 files changed

// File: rtl/snax_simd_alu_shell_wrapper.sv
// SNAX accelerator shell: joins two operand streams through a NumLanes-wide SIMD ALU
// (ADD/SUB/MUL/XOR) into one double-width result stream, configured over the CSR manager.
module snax_simd_alu_shell_wrapper #(
  parameter int unsigned NumLanes     = 4,
  parameter int unsigned LaneWidth    = 16,
  parameter int unsigned RegRWCount   = 3,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  output logic [NumLanes*2*LaneWidth-1:0]    acc2stream_0_data_o,
  output logic                               acc2stream_0_valid_o,
  input  logic                               acc2stream_0_ready_i,
  input  logic [NumLanes*LaneWidth-1:0]      stream2acc_0_data_i,
  input  logic                               stream2acc_0_valid_i,
  output logic                               stream2acc_0_ready_o,
  input  logic [NumLanes*LaneWidth-1:0]      stream2acc_1_data_i,
  input  logic                               stream2acc_1_valid_i,
  output logic                               stream2acc_1_ready_o,
  input  logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i,
  input  logic                               csr_reg_set_valid_i,
  output logic                               csr_reg_set_ready_o,
  output logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o
);

  localparam int unsigned OutW = NumLanes * 2 * LaneWidth;
  localparam int unsigned ResW = 2 * LaneWidth;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [RegDataWidth-1:0] beats_left_q, beats_left_d;
  logic [RegDataWidth-1:0] cycles_q, cycles_d;
  logic                    out_valid_q, out_valid_d;
  logic [OutW-1:0]         out_data_q, out_data_d;
  logic [OutW-1:0]         result;
  logic                    csr_fire, can_take, take;
  logic                    unused_csr;

  // Operands are sign-extended first so the double-width result never wraps.
  function automatic logic signed [ResW-1:0] lane_op(input logic [1:0] op,
                                                     input logic signed [LaneWidth-1:0] a,
                                                     input logic signed [LaneWidth-1:0] b);
    logic signed [ResW-1:0] ax, bx;
    ax = {{LaneWidth{a[LaneWidth-1]}}, a};
    bx = {{LaneWidth{b[LaneWidth-1]}}, b};
    unique case (op)
      2'd0:    lane_op = ax + bx;
      2'd1:    lane_op = ax - bx;
      2'd2:    lane_op = ax * bx;
      default: lane_op = {{LaneWidth{1'b0}}, a ^ b};
    endcase
  endfunction

  assign unused_csr = ^csr_reg_set_i;

  always_comb begin
    result = '0;
    for (int i = 0; i < NumLanes; i++) begin
      result[i*ResW +: ResW] = lane_op(mode_q,
                                       stream2acc_0_data_i[i*LaneWidth +: LaneWidth],
                                       stream2acc_1_data_i[i*LaneWidth +: LaneWidth]);
    end
  end

  assign csr_fire = csr_reg_set_valid_i && (state_q == IDLE);
  assign can_take = (state_q == BUSY) && (beats_left_q != '0) &&
                    (!out_valid_q || acc2stream_0_ready_i);
  assign take     = can_take && stream2acc_0_valid_i && stream2acc_1_valid_i;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    beats_left_d = beats_left_q;
    cycles_d     = cycles_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (out_valid_q && acc2stream_0_ready_i) out_valid_d = 1'b0;
    if (take) begin
      out_valid_d  = 1'b1;
      out_data_d   = result;
      beats_left_d = beats_left_q - RegDataWidth'(1);
    end
    if ((state_q == BUSY) && (cycles_q != '1)) cycles_d = cycles_q + RegDataWidth'(1);

    unique case (state_q)
      IDLE: begin
        if (csr_fire) begin
          mode_d = csr_reg_set_i[1:0];
          if (csr_reg_set_i[2*RegDataWidth] &&
              (csr_reg_set_i[RegDataWidth +: RegDataWidth] != '0)) begin
            state_d      = BUSY;
            beats_left_d = csr_reg_set_i[RegDataWidth +: RegDataWidth];
            cycles_d     = '0;
          end
        end
      end
      default: begin
        // Finish once every beat is taken and the result register is empty or leaving now.
        if ((beats_left_q == '0) && (!out_valid_q || acc2stream_0_ready_i)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      mode_q       <= 2'd0;
      beats_left_q <= '0;
      cycles_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      beats_left_q <= beats_left_d;
      cycles_q     <= cycles_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  always_comb begin
    csr_reg_ro_set_o                                 = '0;
    csr_reg_ro_set_o[0]                              = (state_q == BUSY);
    csr_reg_ro_set_o[RegDataWidth +: RegDataWidth]   = cycles_q;
  end

  assign csr_reg_set_ready_o  = (state_q == IDLE);
  assign acc2stream_0_data_o  = out_data_q;
  assign acc2stream_0_valid_o = out_valid_q;
  assign stream2acc_0_ready_o = can_take && stream2acc_1_valid_i;
  assign stream2acc_1_ready_o = can_take && stream2acc_0_valid_i;

endmodule
